// File: rtl/mem_io_bus.sv
// mem_io_bus -- data-side address decoder and peripheral block behind the
// CPU MEM stage. Word accesses are routed either to the external data RAM
// (low window) or to on-block I/O registers (LED, switches, compare timer).
// Read data is returned combinationally in the same cycle.
//
// Ports:
//   clk        CPU clock, all state on rising edge
//   rst        asynchronous active-low reset
//   Addr_out   byte address from EX/MEM (bits [1:0] ignored)
//   Data_out   store data
//   MemRW_Mem  1 = write, 0 = read / idle
//   Data_in    combinational read data back to the CPU
//   ram_addr   RAM word address
//   ram_din    RAM write data
//   ram_we     RAM write enable (decode only, not gated by reset)
//   ram_dout   RAM combinational read data
//   sw         raw board switches (asynchronous)
//   led        LED register
//   timer_irq  timer match flag (level)

// Two-flop synchroniser for one switch bit.
module mem_io_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] stg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stg <= '0;
    else      stg <= {stg[0], d};
  end

  assign q = stg[1];
endmodule

module mem_io_bus #(
  parameter int RAM_AW = 10,
  parameter int SW_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  input  logic              MemRW_Mem,
  output logic [31:0]       Data_in,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [SW_W-1:0]   sw,
  output logic [SW_W-1:0]   led,
  output logic              timer_irq
);
  localparam logic [23:0] IO_BASE  = 24'hF00000;
  localparam logic [5:0]  OFF_LED  = 6'h00;
  localparam logic [5:0]  OFF_SW   = 6'h01;
  localparam logic [5:0]  OFF_CNT  = 6'h02;
  localparam logic [5:0]  OFF_CMP  = 6'h03;
  localparam logic [5:0]  OFF_CTRL = 6'h04;

  typedef struct packed {
    logic        ram;
    logic        io;
    logic [5:0]  off;
    logic        wr;
    logic [31:0] wdata;
  } bus_req_t;

  bus_req_t         req;
  logic [SW_W-1:0]  sw_sync;
  logic [31:0]      cnt, cmp, io_rdata;
  logic             en, reload, flag, match;
  logic             wr_led, wr_cnt, wr_cmp, wr_ctrl;
  logic             unused_addr;

  // ---------------------------------------------------------------- decode
  always_comb begin
    req.ram   = (Addr_out[31:RAM_AW+2] == '0);
    req.io    = (Addr_out[31:8] == IO_BASE);
    req.off   = Addr_out[7:2];
    req.wr    = MemRW_Mem;
    req.wdata = Data_out;
  end

  // Byte lane bits carry no meaning on a word-only bus.
  assign unused_addr = ^Addr_out[1:0];

  assign ram_addr = Addr_out[RAM_AW+1:2];
  assign ram_din  = Data_out;
  assign ram_we   = req.wr & req.ram;

  assign wr_led  = req.wr & req.io & (req.off == OFF_LED);
  assign wr_cnt  = req.wr & req.io & (req.off == OFF_CNT);
  assign wr_cmp  = req.wr & req.io & (req.off == OFF_CMP);
  assign wr_ctrl = req.wr & req.io & (req.off == OFF_CTRL);

  // ------------------------------------------------------------ read mux
  // Shows pre-write register state; writes appear the following cycle.
  always_comb begin
    io_rdata = '0;
    case (req.off)
      OFF_LED:  io_rdata[SW_W-1:0] = led;
      OFF_SW:   io_rdata[SW_W-1:0] = sw_sync;
      OFF_CNT:  io_rdata           = cnt;
      OFF_CMP:  io_rdata           = cmp;
      OFF_CTRL: io_rdata[2:0]      = {flag, reload, en};
      default:  io_rdata           = '0;
    endcase
    Data_in = '0;
    if (req.ram)     Data_in = ram_dout;
    else if (req.io) Data_in = io_rdata;
  end

  // ------------------------------------------------------ switch synchroniser
  for (genvar i = 0; i < SW_W; i++) begin : g_sync
    mem_io_sync_bit u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sw[i]),
      .q   (sw_sync[i])
    );
  end

  // ------------------------------------------------------------- LED
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        led <= '0;
    else if (wr_led) led <= req.wdata[SW_W-1:0];
  end

  // ------------------------------------------------------------- timer
  // Match uses the EN and CMP values from before this edge's writes.
  assign match = en & (cnt == cmp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en     <= 1'b0;
      reload <= 1'b0;
      cmp    <= '1;
    end else begin
      if (wr_ctrl) begin
        en     <= req.wdata[0];
        reload <= req.wdata[1];
      end
      if (wr_cmp) cmp <= req.wdata;
    end
  end

  // A CPU write to CNT beats both reload and increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (wr_cnt)          cnt <= req.wdata;
    else if (match && reload) cnt <= '0;
    else if (en)              cnt <= cnt + 32'd1;
  end

  // Set on match wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            flag <= 1'b0;
    else if (match)                      flag <= 1'b1;
    else if (wr_ctrl && req.wdata[2])    flag <= 1'b0;
  end

  assign timer_irq = flag;
endmodule

// File: tb/tb_mem_io_bus.sv
module tb_mem_io_bus;
  localparam int RAM_AW = 10;
  localparam int SW_W   = 16;
  localparam logic [31:0] A_LED  = 32'hF000_0000;
  localparam logic [31:0] A_SW   = 32'hF000_0004;
  localparam logic [31:0] A_CNT  = 32'hF000_0008;
  localparam logic [31:0] A_CMP  = 32'hF000_000C;
  localparam logic [31:0] A_CTRL = 32'hF000_0010;

  logic              clk = 1'b0, rst = 1'b0;
  logic [31:0]       Addr_out = '0, Data_out = '0;
  logic              MemRW_Mem = 1'b0;
  logic [31:0]       Data_in, ram_din, ram_dout;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we, timer_irq;
  logic [SW_W-1:0]   sw = '0, led;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  mem_io_bus #(.RAM_AW(RAM_AW), .SW_W(SW_W)) dut (
    .clk(clk), .rst(rst), .Addr_out(Addr_out), .Data_out(Data_out),
    .MemRW_Mem(MemRW_Mem), .Data_in(Data_in), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout), .sw(sw),
    .led(led), .timer_irq(timer_irq)
  );

  // external RAM environment
  logic [31:0] ram_mem [1024];
  assign ram_dout = ram_mem[ram_addr];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_din;

  // ------------------------------------------------ reference model state
  logic [31:0] m_mem [1024];
  logic [15:0] m_led, m_s1, m_s2;
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_rl, m_flag;

  // per-cycle observations
  logic [31:0] obs_rd, exp_rd;
  logic        obs_we, exp_we;
  logic [9:0]  obs_ad;

  task automatic model_reset();
    m_led = '0; m_s1 = '0; m_s2 = '0;
    m_cnt = '0; m_cmp = 32'hFFFF_FFFF;
    m_en = 1'b0; m_rl = 1'b0; m_flag = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:12] == 20'h0) return m_mem[a[11:2]];
    if (a[31:8] == 24'hF00000) begin
      case (a[7:2])
        6'd0: return {16'h0, m_led};
        6'd1: return {16'h0, m_s2};
        6'd2: return m_cnt;
        6'd3: return m_cmp;
        6'd4: return {29'h0, m_flag, m_rl, m_en};
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // one rising edge of the block, from the written rules
  task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w);
    logic io, hit;
    logic [5:0] off;
    logic [31:0] ncnt;
    logic nflag;
    io  = (a[31:8] == 24'hF00000);
    off = a[7:2];
    hit = m_en && (m_cnt == m_cmp);
    if (w && io && off == 6'd2) ncnt = d;
    else if (!m_en)             ncnt = m_cnt;
    else if (hit && m_rl)       ncnt = 32'h0;
    else                        ncnt = m_cnt + 32'd1;
    if (hit)                                nflag = 1'b1;
    else if (w && io && off == 6'd4 && d[2]) nflag = 1'b0;
    else                                    nflag = m_flag;
    if (w && io && off == 6'd4) begin m_en = d[0]; m_rl = d[1]; end
    if (w && io && off == 6'd3) m_cmp = d;
    if (w && io && off == 6'd0) m_led = d[15:0];
    if (w && a[31:12] == 20'h0) m_mem[a[11:2]] = d;
    m_s2 = m_s1; m_s1 = sw;
    m_cnt = ncnt; m_flag = nflag;
  endtask

  // drive one bus cycle, sample combinational outputs, advance one edge
  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic w);
    Addr_out = a; Data_out = d; MemRW_Mem = w;
    exp_rd = model_read(a);
    exp_we = w && (a[31:12] == 20'h0);
    #1;
    obs_rd = Data_in; obs_we = ram_we; obs_ad = ram_addr;
    @(posedge clk);
    model_step(a, d, w);
    #1;
    MemRW_Mem = 1'b0;
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] addrs [5];
    logic [31:0] vals [5];
    addrs = '{A_LED, A_SW, A_CNT, A_CMP, A_CTRL};
    vals  = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    model_reset();
    rst = 1'b0; sw = 16'hFFFF;
    Addr_out = 32'h10; MemRW_Mem = 1'b1; #1;
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL reset_ram_we got %b want 1", ram_we); end
    MemRW_Mem = 1'b0; #1;
    vectors++; if (led !== 16'h0) begin miscompares++; $display("FAIL reset_led got %h want 0", led); end
    vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", timer_irq); end
    for (int i = 0; i < 5; i++) begin
      Addr_out = addrs[i]; #1;
      vectors++;
      if (Data_in !== vals[i]) begin miscompares++; $display("FAIL reset_reg%0d got %h want %h", i, Data_in, vals[i]); end
    end
    sw = '0;
    @(negedge clk); rst = 1'b1;
    bus_cycle(A_CNT, 0, 0);
    vectors++; if (obs_rd !== 32'h0) begin miscompares++; $display("FAIL reset_release_cnt got %h want 0", obs_rd); end
  endtask

  task automatic test_ram();
    bus_cycle(32'h0000_0010, 32'hDEAD_BEEF, 1);
    vectors++; if (obs_we !== 1'b1) begin miscompares++; $display("FAIL ram_wr_we got %b want 1", obs_we); end
    vectors++; if (obs_ad !== 10'd4) begin miscompares++; $display("FAIL ram_wr_addr got %0d want 4", obs_ad); end
    bus_cycle(32'h0000_0010, 32'h0, 0);
    vectors++; if (obs_rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ram_rd got %h want deadbeef", obs_rd); end
    vectors++; if (obs_we !== 1'b0) begin miscompares++; $display("FAIL ram_rd_we got %b want 0", obs_we); end
  endtask

  task automatic test_led();
    bus_cycle(A_LED, 32'h0000_A5A5, 1);
    vectors++; if (led !== 16'hA5A5) begin miscompares++; $display("FAIL led_out got %h want a5a5", led); end
    vectors++; if (obs_we !== 1'b0) begin miscompares++; $display("FAIL led_ram_we got %b want 0", obs_we); end
    bus_cycle(A_LED, 32'h0, 0);
    vectors++; if (obs_rd !== 32'h0000_A5A5) begin miscompares++; $display("FAIL led_rd got %h want 0000a5a5", obs_rd); end
  endtask

  task automatic test_sw();
    logic [31:0] want [4];
    want = '{32'h0, 32'h0, 32'h1234, 32'h1234};
    sw = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      bus_cycle(A_SW, 32'h0, 0);
      vectors++;
      if (obs_rd !== want[i] || obs_rd !== exp_rd)
        begin miscompares++; $display("FAIL sw_sync_%0d got %h want %h", i, obs_rd, want[i]); end
    end
  endtask

  task automatic test_timer_reload();
    logic [31:0] seq [6];
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    bus_cycle(A_CMP, 32'd3, 1);
    bus_cycle(A_CNT, 32'd0, 1);
    bus_cycle(A_CTRL, 32'd3, 1);
    for (int i = 0; i < 6; i++) begin
      bus_cycle(A_CNT, 32'h0, 0);
      vectors++;
      if (obs_rd !== seq[i]) begin miscompares++; $display("FAIL reload_cnt_%0d got %0d want %0d", i, obs_rd, seq[i]); end
      vectors++;
      if (timer_irq !== (i >= 3)) begin miscompares++; $display("FAIL reload_irq_%0d got %b want %b", i, timer_irq, (i >= 3)); end
    end
    bus_cycle(A_CTRL, 32'd7, 1);   // cnt=2, plain clear
    vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL w1c_clear got %b want 0", timer_irq); end
    bus_cycle(A_CTRL, 32'd7, 1);   // cnt=3, clear meets match
    vectors++; if (timer_irq !== 1'b1) begin miscompares++; $display("FAIL w1c_vs_match got %b want 1", timer_irq); end
    bus_cycle(A_CTRL, 32'd4, 1);   // clear and disable
    vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL ctrl4_clear got %b want 0", timer_irq); end
    bus_cycle(A_CTRL, 32'h0, 0);
    vectors++; if (obs_rd !== 32'h0) begin miscompares++; $display("FAIL ctrl_rd got %h want 0", obs_rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [8];
    seq = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    bus_cycle(A_CNT, 32'hFFFF_FFFF, 1);
    bus_cycle(A_CMP, 32'd5, 1);
    bus_cycle(A_CTRL, 32'd1, 1);
    for (int j = 0; j < 8; j++) begin
      bus_cycle(A_CNT, 32'h0, 0);
      vectors++;
      if (obs_rd !== seq[j]) begin miscompares++; $display("FAIL wrap_cnt_%0d got %h want %h", j, obs_rd, seq[j]); end
      vectors++;
      if (timer_irq !== (j >= 6)) begin miscompares++; $display("FAIL wrap_irq_%0d got %b want %b", j, timer_irq, (j >= 6)); end
    end
    bus_cycle(A_CNT, 32'h10, 1);
    bus_cycle(A_CNT, 32'h0, 0);
    vectors++; if (obs_rd !== 32'h10) begin miscompares++; $display("FAIL cnt_wr_override got %h want 10", obs_rd); end
    bus_cycle(A_CTRL, 32'd4, 1);
  endtask

  task automatic test_unmapped();
    logic [15:0] led_before;
    led_before = led;
    bus_cycle(32'h8000_0000, 32'hFFFF_FFFF, 1);
    vectors++; if (obs_we !== 1'b0) begin miscompares++; $display("FAIL unmap_we got %b want 0", obs_we); end
    vectors++; if (obs_rd !== 32'h0) begin miscompares++; $display("FAIL unmap_rd got %h want 0", obs_rd); end
    bus_cycle(32'hF000_0040, 32'hFFFF_FFFF, 1);
    vectors++; if (obs_rd !== 32'h0) begin miscompares++; $display("FAIL unmap_io_rd got %h want 0", obs_rd); end
    vectors++; if (led !== led_before) begin miscompares++; $display("FAIL unmap_led got %h want %h", led, led_before); end
    bus_cycle(A_CMP, 32'h0, 0);
    vectors++; if (obs_rd !== 32'd5) begin miscompares++; $display("FAIL unmap_cmp got %h want 5", obs_rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic w;
    int kind;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        d = $urandom;
      end else if (kind < 9) begin
        a = A_LED | ($urandom_range(0, 5) << 2);
        case (a[7:2])
          6'd2, 6'd3: d = $urandom_range(0, 12);
          6'd4:       d = $urandom_range(0, 7);
          default:    d = $urandom;
        endcase
      end else begin
        a = 32'h8000_0000 | $urandom;
        d = $urandom;
      end
      w = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      bus_cycle(a, d, w);
      vectors++;
      if (obs_rd !== exp_rd) begin miscompares++; $display("FAIL rnd_rd_%0d a=%h got %h want %h", n, a, obs_rd, exp_rd); end
      vectors++;
      if (obs_we !== exp_we || obs_ad !== a[11:2])
        begin miscompares++; $display("FAIL rnd_ram_%0d a=%h got we=%b ad=%h want we=%b ad=%h", n, a, obs_we, obs_ad, exp_we, a[11:2]); end
      vectors++;
      if (timer_irq !== m_flag) begin miscompares++; $display("FAIL rnd_irq_%0d got %b want %b", n, timer_irq, m_flag); end
      vectors++;
      if (led !== m_led) begin miscompares++; $display("FAIL rnd_led_%0d got %h want %h", n, led, m_led); end
    end
  endtask

  task automatic test_reset_mid();
    bus_cycle(A_LED, 32'h5A5A, 1);
    bus_cycle(A_CMP, 32'd2, 1);
    bus_cycle(A_CNT, 32'd0, 1);
    bus_cycle(A_CTRL, 32'd1, 1);
    for (int i = 0; i < 4; i++) bus_cycle(A_CNT, 32'h0, 0);
    vectors++; if (timer_irq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_irq got %b want 1", timer_irq); end
    #2; rst = 1'b0; Addr_out = A_CNT; #1;
    model_reset();
    vectors++; if (Data_in !== 32'h0) begin miscompares++; $display("FAIL mid_reset_cnt got %h want 0", Data_in); end
    vectors++; if (led !== 16'h0) begin miscompares++; $display("FAIL mid_reset_led got %h want 0", led); end
    vectors++; if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL mid_reset_irq got %b want 0", timer_irq); end
    Addr_out = A_CTRL; #1;
    vectors++; if (Data_in !== 32'h0) begin miscompares++; $display("FAIL mid_reset_ctrl got %h want 0", Data_in); end
    sw = '0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus_cycle(A_CNT, 32'h0, 0);
      vectors++;
      if (obs_rd !== 32'h0) begin miscompares++; $display("FAIL post_reset_idle_%0d got %h want 0", i, obs_rd); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
    test_reset();
    test_ram();
    test_led();
    test_sw();
    test_timer_reload();
    test_wrap();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
